// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Ports: Clk/Rst_n (sync active-low); Start, A, B, Cin, Sub sampled when not Busy;
//        Busy high during the N compute cycles; Done one-cycle pulse; Sum, Cout, Ovf registered result.
module serial_add_sub_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic co, ci_msb;
  assign a_ch = a_q[k_q*CHUNK +: CHUNK];
  assign b_ch = b_q[k_q*CHUNK +: CHUNK];
  assign {co, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  // carry into the chunk MSB recovered from its sum bit; only meaningful on the last chunk
  assign ci_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
  assign Busy = state_q == RUN;
  assign Done = state_q == DONE;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == RUN) begin
      res_d[k_q*CHUNK +: CHUNK] = s_ch;
      carry_d = co;
      k_d     = k_q + 1'b1;
      if (k_q == KW'(N - 1)) begin
        state_d = DONE;
        sum_d   = res_d;
        cout_d  = co;
        ovf_d   = co ^ ci_msb;
      end
    end else if (Start) begin
      // subtraction as A + ~B + ~Cin, so Cout reads as not-borrow
      state_d = RUN;
      a_d     = A;
      b_d     = Sub ? ~B : B;
      carry_d = Sub ? ~Cin : Cin;
      k_d     = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_add_sub_unit.sv
// tb_serial_add_sub_unit: checks four instances (CHUNK = 4, 1, 8, 16) against vectors and a reference model.
module tb_serial_add_sub_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;
  logic cin_i = 1'b0, sub_i = 1'b0;
  logic busy [4];
  logic done [4];
  logic [15:0] sum_o [4];
  logic cout_o [4];
  logic ovf_o [4];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int C = g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 8 : 16;
    serial_add_sub_unit #(.WIDTH(16), .CHUNK(C)) dut (
      .Clk(clk), .Rst_n(rst_n), .Start(start), .A(a_i), .B(b_i), .Cin(cin_i), .Sub(sub_i),
      .Busy(busy[g]), .Done(done[g]), .Sum(sum_o[g]), .Cout(cout_o[g]), .Ovf(ovf_o[g])
    );
  end
  function automatic int lat_of(input int i);
    return i == 0 ? 4 : i == 1 ? 16 : i == 2 ? 2 : 1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask
  // reference: plain integer arithmetic, signed range test for overflow
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                       output logic [15:0] s, output logic c, output logic o);
    int sa, sbv, r;
    logic [16:0] u;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!sb) begin
      u = {1'b0, a} + {1'b0, b} + 17'(ci);
      r = sa + sbv + int'(ci);
      c = u[16];
    end else begin
      u = {1'b0, a} - {1'b0, b} - 17'(ci);
      r = sa - sbv - int'(ci);
      c = {1'b0, a} >= {1'b0, b} + 17'(ci);
    end
    s = u[15:0];
    o = r > 32767 || r < -32768;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input logic [15:0] es, input logic ec, input logic eo);
    int lat [4];
    int bc [4];
    int dc [4];
    int clash;
    clash = 0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1;
      bc[i] = 0;
      dc[i] = 0;
    end
    start = 1'b1; a_i = a; b_i = b; cin_i = ci; sub_i = sb;
    tick();
    start = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
    for (int c = 0; c < 19; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (busy[i]) bc[i]++;
        if (done[i]) dc[i]++;
        if (done[i] && lat[i] < 0) lat[i] = c;
        if (busy[i] && done[i]) clash++;
      end
      tick();
    end
    chk({nm, " busy_done_overlap"}, clash, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s dut%0d latency", nm, i), lat[i], lat_of(i));
      chk($sformatf("%s dut%0d busy_cycles", nm, i), bc[i], lat_of(i));
      chk($sformatf("%s dut%0d done_cycles", nm, i), dc[i], 1);
      chk($sformatf("%s dut%0d sum", nm, i), sum_o[i], es);
      chk($sformatf("%s dut%0d cout", nm, i), cout_o[i], ec);
      chk($sformatf("%s dut%0d ovf", nm, i), ovf_o[i], eo);
    end
  endtask
  typedef struct {
    logic [15:0] a, b;
    logic ci, sb;
    logic [15:0] s;
    logic c, o;
  } vec_t;
  vec_t tv [5];
  initial begin
    logic [15:0] ra, rb, es;
    logic rc, rs, ec, eo;
    int t;
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[4] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset dut%0d busy", i), busy[i], 0);
      chk($sformatf("reset dut%0d done", i), done[i], 0);
      chk($sformatf("reset dut%0d sum", i), sum_o[i], 0);
      chk($sformatf("reset dut%0d cout", i), cout_o[i], 0);
      chk($sformatf("reset dut%0d ovf", i), ovf_o[i], 0);
    end
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 5; v++)
      run_op($sformatf("vec%0d", v), tv[v].a, tv[v].b, tv[v].ci, tv[v].sb, tv[v].s, tv[v].c, tv[v].o);
    // Start during RUN is ignored; Sum keeps the previous result until Done
    start = 1'b1; a_i = 16'h0100; b_i = 16'h0023; cin_i = 1'b0; sub_i = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a_i = 16'h1234; b_i = 16'h1111;
    chk("ignore sum_held", sum_o[0], 16'h000C);
    tick();
    start = 1'b0;
    t = 0;
    while (!done[0] && t < 30) begin
      tick();
      t++;
    end
    chk("ignore done_seen", done[0], 1);
    chk("ignore sum", sum_o[0], 16'h0123);
    repeat (20) tick();
    // back-to-back: second Start in the Done cycle
    start = 1'b1; a_i = 16'h00FF; b_i = 16'h0001;
    tick();
    start = 1'b0;
    t = 0;
    while (!done[0] && t < 30) begin
      tick();
      t++;
    end
    chk("b2b first_done", done[0], 1);
    chk("b2b first_sum", sum_o[0], 16'h0100);
    start = 1'b1; a_i = 16'h0001; b_i = 16'h0002;
    tick();
    start = 1'b0;
    chk("b2b busy_again", busy[0], 1);
    chk("b2b done_low", done[0], 0);
    t = 1;
    while (!done[0] && t < 30) begin
      tick();
      t++;
    end
    chk("b2b done_spacing", t, 5);
    chk("b2b second_sum", sum_o[0], 16'h0003);
    repeat (20) tick();
    // reset in the second RUN cycle discards the operation
    start = 1'b1; a_i = 16'h0005; b_i = 16'h0005;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset busy", busy[0], 0);
    chk("midreset done", done[0], 0);
    chk("midreset sum", sum_o[0], 0);
    chk("midreset cout", cout_o[0], 0);
    chk("midreset ovf", ovf_o[0], 0);
    t = 0;
    for (int c = 0; c < 20; c++) begin
      if (done[0] || busy[0]) t++;
      tick();
    end
    chk("midreset no_activity", t, 0);
    for (int r = 0; r < 30; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (r % 5 == 0) rb = ra;
      model(ra, rb, rc, rs, es, ec, eo);
      run_op($sformatf("rand%0d", r), ra, rb, rc, rs, es, ec, eo);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
